fp_result_buffer: RTL and testbench

Credit-managed result buffer directly downstream of the floating-point add pipeline (`addFN`, fixed 4-cycle latency, no back-pressure). It captures each completed result and its HardFloat exception flags, holds them in a FIFO, and presents them on a ready/valid port. It tracks operations in flight so the issuing sequencer never launches an add whose result would find the buffer full. It also keeps sticky exception flags for the whole stream.

---
 rtl/fp_stage_pkg.sv | 19 +
 rtl/fp_result_buffer.sv | 132 +++++++++++++
 tb/tb_fp_result_buffer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_stage_pkg.sv
// Shared definitions for the floating-point add stage: HardFloat flag layout and
// error-bit indices used by the result buffer.
package fp_stage_pkg;

    localparam int unsigned FLAG_W = 5;

    localparam int unsigned FLAG_INVALID   = 4;
    localparam int unsigned FLAG_INFINITE  = 3;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_INEXACT   = 0;

    typedef logic [FLAG_W-1:0] flags_t;

    localparam int unsigned ERR_W        = 2;
    localparam int unsigned ERR_DROP     = 0;
    localparam int unsigned ERR_SPURIOUS = 1;

endpackage

// File: rtl/fp_result_buffer.sv
// Credit-managed FIFO behind the fixed-latency adder: captures results and flags,
// tracks operations in flight and keeps sticky exception flags.
module fp_result_buffer
    import fp_stage_pkg::*;
#(
    parameter int unsigned expWidth = 8,
    parameter int unsigned sigWidth = 24,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned LATENCY  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               issue,
    output logic                               can_issue,
    input  logic                               res_done,
    input  logic [expWidth+sigWidth-1:0]       res_data,
    input  flags_t                             res_flags,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [expWidth+sigWidth-1:0]       out_data,
    output flags_t                             out_flags,
    output flags_t                             sticky_flags,
    input  logic                               clear_sticky,
    output logic [$clog2(DEPTH+1)-1:0]         count,
    output logic [ERR_W-1:0]                   err
);

    localparam int unsigned W  = expWidth + sigWidth;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so forced issues beyond the credit limit stay countable
    localparam int unsigned IW = CW + 1;

    if (DEPTH < LATENCY) begin : g_cfg_err
        $error("fp_result_buffer: DEPTH must be at least LATENCY");
    end

    typedef struct packed {
        logic [W-1:0] data;
        flags_t       flags;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [IW-1:0]     inflight_q, inflight_d;
    flags_t            sticky_q, sticky_d;
    logic [ERR_W-1:0]  err_q, err_d;

    logic push, pop, full, drop, spurious;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        err_d      = err_q;

        full     = (count_q == CW'(DEPTH));
        pop      = (count_q != '0) && out_ready;
        push     = res_done && (!full || pop);
        drop     = res_done && full && !pop;
        spurious = res_done && (inflight_q == '0);

        if (push) begin
            mem_d[wr_ptr_q] = '{data: res_data, flags: res_flags};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // A done with nothing outstanding is not allowed to take the counter below zero
        if (issue && !res_done && (inflight_q != '1)) begin
            inflight_d = inflight_q + IW'(1);
        end else if (!issue && res_done && (inflight_q != '0)) begin
            inflight_d = inflight_q - IW'(1);
        end else if (issue && res_done && (inflight_q == '0)) begin
            inflight_d = IW'(1);
        end

        sticky_d = (clear_sticky ? flags_t'(0) : sticky_q) | (push ? res_flags : flags_t'(0));

        err_d[ERR_DROP]     = err_q[ERR_DROP] | drop;
        err_d[ERR_SPURIOUS] = err_q[ERR_SPURIOUS] | spurious;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            sticky_q   <= '0;
            err_q      <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            sticky_q   <= sticky_d;
            err_q      <= err_d;
        end
    end

    // Outputs depend on registered state only; no path from res_* to the head
    assign can_issue    = ((IW+1)'(count_q) + (IW+1)'(inflight_q)) < (IW+1)'(DEPTH);
    assign out_valid    = (count_q != '0);
    assign out_data     = mem_q[rd_ptr_q].data;
    assign out_flags    = mem_q[rd_ptr_q].flags;
    assign sticky_flags = sticky_q;
    assign count        = count_q;
    assign err          = err_q;

endmodule

// File: tb/tb_fp_result_buffer.sv
// Directed bench for fp_result_buffer: reset, single result, credit exhaustion,
// full push/pop, wrap ordering, sticky clear collision and spurious done.
module tb_fp_result_buffer;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          issue;
    logic          can_issue;
    logic          res_done;
    logic [W-1:0]  res_data;
    logic [4:0]    res_flags;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [4:0]    out_flags;
    logic [4:0]    sticky_flags;
    logic          clear_sticky;
    logic [CW-1:0] count;
    logic [1:0]    err;

    int n_tests = 0;
    int n_fail  = 0;

    fp_result_buffer #(
        .expWidth(8), .sigWidth(24), .DEPTH(DEPTH), .LATENCY(4)
    ) dut (
        .clk(clk), .reset(reset), .issue(issue), .can_issue(can_issue),
        .res_done(res_done), .res_data(res_data), .res_flags(res_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .sticky_flags(sticky_flags),
        .clear_sticky(clear_sticky), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue        = 1'b0;
        res_done     = 1'b0;
        res_data     = '0;
        res_flags    = '0;
        out_ready    = 1'b0;
        clear_sticky = 1'b0;
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int stage [4];
    int next_tag;
    int exp_tag;
    int cyc;

    initial begin
        idle();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_can_issue", 32'(can_issue), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_sticky", 32'(sticky_flags), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        reset = 1'b1;
        step();
        check("idle_can_issue", 32'(can_issue), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Single result, returned four cycles after its issue
        issue = 1'b1;
        step();
        idle();
        step(); step(); step();
        res_done  = 1'b1;
        res_data  = 32'h4040_0000;
        res_flags = 5'b00001;
        step();
        idle();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", out_data, 32'h4040_0000);
        check("single_flags", 32'(out_flags), 32'h01);
        check("single_sticky", 32'(sticky_flags), 32'h01);
        check("single_count", 32'(count), 32'd1);
        check("single_err", 32'(err), 32'd0);
        out_ready = 1'b1;
        step();
        idle();
        check("single_pop_count", 32'(count), 32'd0);
        check("single_pop_valid", 32'(out_valid), 32'd0);

        // Credit exhaustion: eight issues, results come back from cycle 4
        for (int c = 0; c < 12; c++) begin
            issue    = (c < 8);
            res_done = (c >= 4);
            res_data = 32'h100 + 32'(c - 4);
            step();
            if (c == 6) check("credit_c6_can_issue", 32'(can_issue), 32'd1);
            if (c == 7) check("credit_c7_can_issue", 32'(can_issue), 32'd0);
        end
        idle();
        check("credit_full_count", 32'(count), 32'd8);
        check("credit_full_can_issue", 32'(can_issue), 32'd0);
        check("credit_head", out_data, 32'h100);

        // Full buffer, push and pop together
        issue = 1'b1;
        step();
        idle();
        res_done  = 1'b1;
        res_data  = 32'h200;
        out_ready = 1'b1;
        step();
        idle();
        check("fullpp_count", 32'(count), 32'd8);
        check("fullpp_err", 32'(err), 32'd0);
        check("fullpp_head", out_data, 32'h101);

        // Forced ninth issue whose result finds the buffer full
        issue = 1'b1;
        step();
        idle();
        res_done = 1'b1;
        res_data = 32'h201;
        step();
        idle();
        check("drop_err", 32'(err), 32'b01);
        check("drop_count", 32'(count), 32'd8);

        // Asynchronous reset takes effect before any clock edge
        reset = 1'b0;
        #2;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_err", 32'(err), 32'd0);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Stream 20 tagged results through the 8-deep buffer with random back-pressure
        for (int k = 0; k < 4; k++) stage[k] = 0;
        next_tag = 1;
        exp_tag  = 1;
        cyc      = 0;
        while (exp_tag <= 20 && cyc < 600) begin
            issue     = can_issue && (next_tag <= 20);
            res_done  = (stage[3] != 0);
            res_data  = 32'(stage[3]);
            res_flags = 5'(stage[3]);
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                check("stream_order", out_data, 32'(exp_tag));
                exp_tag++;
            end
            stage[3] = stage[2];
            stage[2] = stage[1];
            stage[1] = stage[0];
            stage[0] = issue ? next_tag : 0;
            if (issue) next_tag++;
            step();
            cyc++;
        end
        idle();
        check("stream_all_received", 32'(exp_tag), 32'd21);
        check("stream_err", 32'(err), 32'd0);
        check("stream_count", 32'(count), 32'd0);
        check("stream_sticky", 32'(sticky_flags), 32'h1f);

        // Clear in the same cycle as a flagged push: the new flag survives
        issue = 1'b1;
        step();
        idle();
        step(); step(); step();
        res_done     = 1'b1;
        res_data     = 32'hABC;
        res_flags    = 5'b10000;
        clear_sticky = 1'b1;
        step();
        idle();
        check("clear_collide_sticky", 32'(sticky_flags), 32'h10);
        check("clear_collide_data", out_data, 32'hABC);
        check("clear_collide_err", 32'(err), 32'd0);

        // Done with nothing in flight
        res_done = 1'b1;
        res_data = 32'hDEF;
        step();
        idle();
        check("spurious_err", 32'(err), 32'b10);
        check("spurious_count", 32'(count), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
